// File: rtl/sm_addsub_datapath.sv
// Signed-magnitude add/subtract datapath driven by one-hot timing lines T0..T7.
// Operand registers A/As and B/Bs, carry flag E, sticky overflow and a done pulse.
// Optional feature: define NEG_ZERO_FIX_EN to force a +0 sign on a zero difference at T5.
module sm_addsub_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             T0,
  input  logic             T1,
  input  logic             T2,
  input  logic             T3,
  input  logic             T4,
  input  logic             T5,
  input  logic             T6,
  input  logic             T7,
  input  logic             load,
  input  logic [WIDTH-1:0] a_in,
  input  logic             as_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bs_in,
  output logic             S,
  output logic             E,
  output logic [WIDTH-1:0] result_mag,
  output logic             result_sign,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             as_q, as_d, bs_q, bs_d;
  logic             e_q, e_d, ovf_q, ovf_d, done_q, done_d;

  logic [WIDTH:0]   add_sum, sub_sum;
  logic [WIDTH-1:0] a_inc;
  logic             a_zero;

  // Shared arithmetic for the T3/T4/T7 steps.
  always_comb begin
    add_sum = {1'b0, a_q} + {1'b0, b_q};
    sub_sum = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
    a_inc   = a_q + {{(WIDTH - 1){1'b0}}, 1'b1};
    a_zero  = (a_q == '0);
  end

  // Next-state: the highest-numbered active T line wins.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    as_d   = as_q;
    bs_d   = bs_q;
    e_d    = e_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (T7) begin
      a_d    = a_inc;
      as_d   = ~as_q;
      done_d = 1'b1;
    end else if (T6) begin
      a_d = ~a_q;
    end else if (T5) begin
`ifdef NEG_ZERO_FIX_EN
      if (e_q && a_zero) begin
        as_d = 1'b0;
      end
`endif
      done_d = e_q;
    end else if (T4) begin
      // E=1: A>=B and A holds A-B; E=0: A holds the two's complement of B-A.
      {e_d, a_d} = sub_sum;
    end else if (T3) begin
      {e_d, a_d} = add_sum;
      // Overflow stays flagged until the next load.
      ovf_d      = ovf_q | add_sum[WIDTH];
      done_d     = 1'b1;
    end else if (T2) begin
      // Sign comparison cycle only; S is sampled by the sequencer.
    end else if (T1) begin
      bs_d = ~bs_q;
    end else if (T0 && load) begin
      a_d   = a_in;
      as_d  = as_in;
      b_d   = b_in;
      bs_d  = bs_in;
      e_d   = 1'b0;
      ovf_d = 1'b0;
    end
  end

  // State registers; synchronous reset discards any pending step.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      as_q   <= 1'b0;
      bs_q   <= 1'b0;
      e_q    <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      as_q   <= as_d;
      bs_q   <= bs_d;
      e_q    <= e_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  // Outputs: registered state plus combinational S and busy.
  always_comb begin
    S           = as_q ^ bs_q;
    E           = e_q;
    result_mag  = a_q;
    result_sign = as_q;
    ovf         = ovf_q;
    done        = done_q;
    busy        = ~T0;
  end

  // Keep a_zero referenced when the zero-sign fix is compiled out.
  logic unused_a_zero;
  always_comb unused_a_zero = a_zero;

endmodule
